iter_muldiv_unit: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.

---
 rtl/iter_muldiv_unit.sv | 180 ++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
// ============================================================================
// Module      : iter_muldiv_unit
// Description : Multi-cycle signed/unsigned multiply/divide unit holding the
//               architectural HI/LO registers. Radix-2 shift-add multiply and
//               restoring shift-subtract divide, one step per cycle, with
//               flush, MTHI/MTLO writes and a busy stall handshake.
//               Optional macro MULDIV_FAST_MULT_EN: MULT/MULTU skip the
//               iterative phase and form the product combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opr1,
  input  logic [WIDTH-1:0] opr2,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0]   acc_q;      // mult: {partial hi, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     a_q;        // |opr1|
  logic [WIDTH-1:0]     b_q;        // |opr2|
  logic                 neg_q;      // product / quotient must be negated
  logic                 rem_neg_q;  // remainder takes the dividend sign
  logic                 is_mul_q;
  logic                 dz_q;       // divide by zero
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  // Operand sign and magnitude (signed ops are 0 and 2, i.e. op[0]==0)
  logic             w_s1, w_s2;
  logic [WIDTH-1:0] w_mag1, w_mag2;
  assign w_s1   = ~op[0] & opr1[WIDTH-1];
  assign w_s2   = ~op[0] & opr2[WIDTH-1];
  assign w_mag1 = w_s1 ? -opr1 : opr1;
  assign w_mag2 = w_s2 ? -opr2 : opr2;

  // Multiply step: conditionally add the multiplicand into the upper half, shift right
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign w_mul_step = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift in the next dividend bit, keep the trial difference if non-negative
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_step;
  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, b_q};
  assign w_div_ge    = ~w_div_diff[WIDTH+1];
  assign w_div_step  = w_div_ge ? {w_div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                : {w_div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  // Unsigned product magnitude presented to the sign-fix stage
  logic [2*WIDTH-1:0] w_prod;
`ifdef MULDIV_FAST_MULT_EN
  assign w_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`else
  assign w_prod = acc_q;
`endif

  // Sign fix-up of the final results
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_hi_fix, w_lo_fix;
  assign w_prod_s = neg_q ? -w_prod : w_prod;
  assign w_quo    = acc_q[WIDTH-1:0];
  assign w_rem    = acc_q[2*WIDTH-1:WIDTH];
  assign w_hi_fix = is_mul_q ? w_prod_s[2*WIDTH-1:WIDTH]
                             : (rem_neg_q ? -w_rem : w_rem);
  assign w_lo_fix = is_mul_q ? w_prod_s[WIDTH-1:0]
                             : (dz_q ? '1 : (neg_q ? -w_quo : w_quo));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: flush aborts from any busy state, and drops a start in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
`ifdef MULDIV_FAST_MULT_EN
          state_d = op[1] ? S_CALC : S_FIX;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (flush)                         state_d = S_IDLE;
        else if (cnt_q == c_CNT_W'(1))     state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      is_mul_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start && !flush) begin
            a_q       <= w_mag1;
            b_q       <= w_mag2;
            neg_q     <= w_s1 ^ w_s2;
            rem_neg_q <= w_s1;
            is_mul_q  <= ~op[1];
            dz_q      <= op[1] & (opr2 == '0);
            cnt_q     <= c_CNT_W'(WIDTH);
            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? w_mag1 : w_mag2)};
          end
        end
        S_CALC: begin
          if (!flush) begin
            acc_q <= is_mul_q ? w_mul_step : w_div_step;
            cnt_q <= cnt_q - c_CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi_q   <= w_hi_fix;
            lo_q   <= w_lo_fix;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_muldiv_unit.sv
// ============================================================================
// Module      : tb_iter_muldiv_unit
// Description : Directed self-checking bench for iter_muldiv_unit (WIDTH=32
//               and WIDTH=8 instances). Honors MULDIV_FAST_MULT_EN for the
//               expected multiply latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_muldiv_unit;

  localparam int W  = 32;
  localparam int W8 = 8;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset, start, flush, hi_we, lo_we, busy, done;
  logic [1:0]   op;
  logic [W-1:0] opr1, opr2, wdata, hi, lo;

  logic          start8, flush8, hi_we8, lo_we8, busy8, done8;
  logic [1:0]    op8;
  logic [W8-1:0] opr1_8, opr2_8, wdata8, hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  iter_muldiv_unit #(.WIDTH(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opr1(opr1), .opr2(opr2),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  iter_muldiv_unit #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .opr1(opr1_8), .opr2(opr2_8),
    .flush(flush8), .hi_we(hi_we8), .lo_we(lo_we8), .wdata(wdata8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle 1; returns the cycle number in which done was seen
  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input int exp_lat);
    int lat;
    op = o; opr1 = a; opr2 = b; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy1"}, busy, 1'b1);
    wait_done(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int lat;
    int nd;
    reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'd0; opr1 = '0; opr2 = '0; wdata = '0;
    start8 = 1'b0; flush8 = 1'b0; hi_we8 = 1'b0; lo_we8 = 1'b0;
    op8 = 2'd0; opr1_8 = '0; opr2_8 = '0; wdata8 = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // Multiply
    op_check("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    op_check("mult_m7x3", 2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    op_check("mult_minsq", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_LAT);

    // Divide
    op_check("div_m7d2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    op_check("divu_max3", 2'd3, 32'hFFFF_FFFF, 32'd3, 32'h0, 32'h5555_5555, DIV_LAT);
    op_check("div_7dm2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT);
    op_check("divu_by0", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, DIV_LAT);
    op_check("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT);
    op_check("div_m7by0", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);

    // Flush in cycle 10 of a DIV: HI/LO keep the previous result
    op = 2'd2; opr1 = 32'd100; opr2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("flush_busy_c10", busy, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_c11", busy, 1'b0);
    check("flush_done_c11", done, 1'b0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("flush_no_done", nd, 0);
    check("flush_hi", hi, 32'hFFFF_FFF9);
    check("flush_lo", lo, 32'hFFFF_FFFF);

    // Flush together with start in IDLE drops the start
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 1'b0);
    tick();
    check("flush_start_done", done, 1'b0);

    // Reset mid-operation clears HI/LO and never produces done
    op = 2'd2; opr1 = 32'd100; opr2 = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_hi", hi, 32'h0);
    check("rstmid_lo", lo, 32'h0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("rstmid_no_done", nd, 0);

    // MTHI/MTLO while busy are ignored
    op = 2'd3; opr1 = 32'd20; opr2 = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    check("wr_busy_hold_hi", hi, 32'h0);
    lat = 5;
    while (done !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("wr_busy_lat", lat, DIV_LAT);
    check("wr_busy_hi", hi, 32'd2);
    check("wr_busy_lo", lo, 32'd3);

    // MTHI/MTLO in IDLE land on the next edge
    tick();
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'd3);
    lo_we = 1'b1; wdata = 32'h5678;
    tick();
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_hi", hi, 32'h1234);

    // Write with start in the same cycle: write lands first, result overwrites it
    op = 2'd1; opr1 = 32'd1; opr2 = 32'd1; start = 1'b1; hi_we = 1'b1; wdata = 32'hAAAA;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("wrstart_hi_c1", hi, 32'hAAAA);
    wait_done(lat);
    check("wrstart_lat", lat, MUL_LAT);
    check("wrstart_hi", hi, 32'h0);
    check("wrstart_lo", lo, 32'h1);

    // start held through busy yields exactly one done
    tick();
    op = 2'd3; opr1 = 32'd20; opr2 = 32'd6; start = 1'b1;
    tick();
    wait_done(lat);
    start = 1'b0;
    nd = (done === 1'b1) ? 1 : 0;
    check("held_lat", lat, DIV_LAT);
    repeat (50) begin
      tick();
      if (done === 1'b1) nd++;
    end
    check("held_one_done", nd, 1);
    check("held_busy", busy, 1'b0);
    check("held_lo", lo, 32'd3);

    // WIDTH=8 instance: DIVU 0xFF/0x10
    op8 = 2'd3; opr1_8 = 8'hFF; opr2_8 = 8'h10; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (done8 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("w8_lat", lat, W8 + 2);
    check("w8_lo", lo8, 8'h0F);
    check("w8_hi", hi8, 8'h0F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
